// File: rtl/periph_bus_pkg.sv
// Shared types and helpers for the peripheral bus host and its address decoder.
package periph_bus_pkg;

   localparam int DATA_W     = 32;
   localparam int MAX_SLAVES = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } host_state_e;

   function automatic logic [MAX_SLAVES-1:0] onehot_sel(input logic [4:0] slot);
      onehot_sel       = '0;
      onehot_sel[slot] = 1'b1;
   endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational byte-address decoder: slot index, window hit and word alignment.
module periph_addr_decode
   import periph_bus_pkg::*;
#(
   parameter int          N_SLAVES  = 4,
   parameter int          SLOT_BITS = 12,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   localparam int         SEL_W     = $clog2(N_SLAVES)
) (
   input  logic [DATA_W-1:0] addr_i,
   output logic [SEL_W-1:0]  slot_o,
   output logic              in_range_o,
   output logic              aligned_o
);

   localparam int HI_LSB = SLOT_BITS + SEL_W;

   assign slot_o     = addr_i[SLOT_BITS +: SEL_W];
   // Every bit above the slot field must equal the base address.
   assign in_range_o = ((addr_i ^ BASE_ADDR) >> HI_LSB) == '0;
   assign aligned_o  = (addr_i[1:0] == 2'b00);

endmodule

// File: rtl/periph_bus_host.sv
// Single-outstanding host turning core valid/ready load-stores into one-cycle
// Avalon-style peripheral strobes, with fixed slave read latency.
module periph_bus_host
   import periph_bus_pkg::*;
#(
   parameter int          N_SLAVES     = 4,
   parameter int          SLOT_BITS    = 12,
   parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
   parameter int          SLAVE_AW     = 3,
   parameter int          READ_LATENCY = 1
) (
   input  logic                       clk_i,
   input  logic                       resetn_i,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic                       req_we_i,
   input  logic [DATA_W-1:0]          req_addr_i,
   input  logic [DATA_W-1:0]          req_wdata_i,
   output logic                       rsp_valid_o,
   output logic [DATA_W-1:0]          rsp_rdata_o,
   output logic                       rsp_err_o,
   output logic [N_SLAVES-1:0]        chipselect_o,
   output logic                       read_o,
   output logic                       write_o,
   output logic [SLAVE_AW-1:0]        address_o,
   output logic [DATA_W-1:0]          writedata_o,
   input  logic [DATA_W*N_SLAVES-1:0] readdata_i,
   output host_state_e                dbg_state_o
);

   localparam int         SEL_W = $clog2(N_SLAVES);
   localparam logic [1:0] LAT   = 2'(READ_LATENCY);

   // Handshake: a request transfers on a rising edge where req_valid_i and
   // req_ready_o are both 1; responses are single-cycle pulses, never stalled.

   host_state_e       state_q;
   logic              we_q;
   logic [SEL_W-1:0]  slot_q;
   logic [1:0]        cnt_q, cnt_d;
   logic              req_ready_q, rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q, writedata_q;
   logic [N_SLAVES-1:0] chipselect_q;
   logic              read_q, write_q;
   logic [SLAVE_AW-1:0] address_q;

   logic [SEL_W-1:0]  dec_slot;
   logic              dec_in_range, dec_aligned;
   logic [DATA_W-1:0] slot_rdata;

   periph_addr_decode #(
      .N_SLAVES  (N_SLAVES),
      .SLOT_BITS (SLOT_BITS),
      .BASE_ADDR (BASE_ADDR)
   ) u_decode (
      .addr_i     (req_addr_i),
      .slot_o     (dec_slot),
      .in_range_o (dec_in_range),
      .aligned_o  (dec_aligned)
   );

   assign cnt_d = cnt_q - 2'd1;

   always_comb begin
      slot_rdata = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (slot_q == SEL_W'(k)) slot_rdata = readdata_i[k*DATA_W +: DATA_W];
      end
   end

   // resetn_i is active-high despite its name.
   always_ff @(posedge clk_i) begin
      if (resetn_i) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         slot_q       <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
         chipselect_q <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         address_q    <= '0;
         writedata_q  <= '0;
      end else begin
         chipselect_q <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  slot_q      <= dec_slot;
                  address_q   <= req_addr_i[2 +: SLAVE_AW];
                  writedata_q <= req_wdata_i;
                  req_ready_q <= 1'b0;
                  if (dec_in_range && dec_aligned) begin
                     state_q      <= ACCESS;
                     chipselect_q <= N_SLAVES'(onehot_sel(5'(dec_slot)));
                     read_q       <= ~req_we_i;
                     write_q      <= req_we_i;
                  end else begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end
               end
            end
            ACCESS: begin
               if (we_q) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= LAT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (cnt_q == 2'd1) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= slot_rdata;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign rsp_err_o    = rsp_err_q;
   assign chipselect_o = chipselect_q;
   assign read_o       = read_q;
   assign write_o      = write_q;
   assign address_o    = address_q;
   assign writedata_o  = writedata_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_periph_bus_host.sv
// Bench for periph_bus_host: directed cases plus randomized traffic scored
// against an address-map / memory reference model; a READ_LATENCY=3 instance.
module tb_periph_bus_host;

   localparam logic [31:0] BASE    = 32'h4000_0000;
   localparam int          NS      = 4;
   localparam int          SLOT_SZ = 4096;
   localparam logic [31:0] L3_VAL  = 32'hCAFE_F000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cyc = '0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance (READ_LATENCY = 1)
   logic         req_valid = 1'b0, req_we = 1'b0;
   logic [31:0]  req_addr = '0, req_wdata = '0;
   logic         req_ready, rsp_valid, rsp_err, rd, wr;
   logic [31:0]  rsp_rdata, wdata_o;
   logic [3:0]   cs;
   logic [2:0]   addr_o;
   logic [127:0] rd_bus = '0;
   logic [1:0]   dbg_state;

   // second instance (READ_LATENCY = 3)
   logic         r3_valid = 1'b0, r3_we = 1'b0;
   logic [31:0]  r3_addr = '0, r3_wdata = '0;
   logic         r3_ready, r3_rsp_valid, r3_rsp_err, r3_rd, r3_wr;
   logic [31:0]  r3_rsp_rdata, r3_wdata_o;
   logic [3:0]   r3_cs;
   logic [2:0]   r3_addr_o;
   logic [127:0] rd3_bus = '0;
   logic [1:0]   r3_dbg;

   periph_bus_host #(.READ_LATENCY(1)) dut (
      .clk_i(clk), .resetn_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .chipselect_o(cs), .read_o(rd), .write_o(wr), .address_o(addr_o),
      .writedata_o(wdata_o), .readdata_i(rd_bus), .dbg_state_o(dbg_state)
   );

   periph_bus_host #(.READ_LATENCY(3)) dut_l3 (
      .clk_i(clk), .resetn_i(rst),
      .req_valid_i(r3_valid), .req_ready_o(r3_ready), .req_we_i(r3_we),
      .req_addr_i(r3_addr), .req_wdata_i(r3_wdata),
      .rsp_valid_o(r3_rsp_valid), .rsp_rdata_o(r3_rsp_rdata), .rsp_err_o(r3_rsp_err),
      .chipselect_o(r3_cs), .read_o(r3_rd), .write_o(r3_wr), .address_o(r3_addr_o),
      .writedata_o(r3_wdata_o), .readdata_i(rd3_bus), .dbg_state_o(r3_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // slave memories: what the bench's slaves hold vs. what the model says they should hold
   logic [31:0] slv_mem [NS][8];
   logic [31:0] ref_mem [NS][8];

   // slaves for the main instance: registered read data one cycle after the strobe, garbage otherwise
   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) begin
         if (rd && cs[k]) rd_bus[k*32 +: 32] <= slv_mem[k][addr_o];
         else             rd_bus[k*32 +: 32] <= $urandom;
         if (wr && cs[k]) slv_mem[k][addr_o] = wdata_o;
      end
   end

   // slaves for the latency-3 instance: two pipeline stages, then registered data
   logic       s0_v = 1'b0, s1_v = 1'b0;
   logic [3:0] s0_cs = '0, s1_cs = '0;
   logic [2:0] s0_a = '0, s1_a = '0;
   always @(posedge clk) begin
      s0_v <= r3_rd;  s0_cs <= r3_cs;  s0_a <= r3_addr_o;
      s1_v <= s0_v;   s1_cs <= s0_cs;  s1_a <= s0_a;
      for (int k = 0; k < NS; k++) begin
         if (s1_v && s1_cs[k]) rd3_bus[k*32 +: 32] <= L3_VAL + 32'(s1_a);
         else                  rd3_bus[k*32 +: 32] <= $urandom;
      end
   end

   // reference address map, from the memory-map rules
   function automatic void decode(input logic [31:0] a, output bit ok, output int slot, output int word);
      ok   = (a >= BASE) && (a < BASE + NS*SLOT_SZ) && (a % 4 == 0);
      slot = int'((a - BASE) / SLOT_SZ);
      word = int'((a / 4) % 8);
   endfunction

   typedef struct packed { logic err; logic [31:0] rdata; logic [31:0] cyc; } rsp_exp_t;
   typedef struct packed { logic we; logic [3:0] cs; logic [2:0] adr; logic [31:0] wdata; logic [31:0] cyc; } bus_exp_t;
   rsp_exp_t exp_q[$];
   bus_exp_t bus_q[$];
   rsp_exp_t mon_r;
   bus_exp_t mon_b;

   // driver: call at a negedge; returns at the negedge after the accept edge with req_valid still high
   task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input bit expect_rsp, output logic [31:0] acc_cyc);
      bit ok, got;
      int slot, word;
      rsp_exp_t r;
      bus_exp_t b;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         if (req_ready) got = 1'b1;
         else @(negedge clk);
      end
      chk("accept_timeout", got, 1);
      acc_cyc = cyc;
      if (!got) begin
         req_valid = 1'b0;
         return;
      end
      decode(a, ok, slot, word);
      if (!ok) begin
         r.err = 1'b1; r.rdata = '0; r.cyc = cyc + 1;
         if (expect_rsp) exp_q.push_back(r);
      end else begin
         b.we = we; b.cs = 4'(1 << slot); b.adr = 3'(word); b.wdata = d; b.cyc = cyc + 1;
         bus_q.push_back(b);
         if (we) ref_mem[slot][word] = d;
         r.err = 1'b0;
         r.rdata = we ? 32'h0 : ref_mem[slot][word];
         r.cyc = we ? cyc + 2 : cyc + 3;
         if (expect_rsp) exp_q.push_back(r);
      end
      @(negedge clk);
   endtask

   // monitor: pops expectations whenever the DUT presents a response or a bus strobe
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            chk("rsp_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               mon_r = exp_q.pop_front();
               chk("rsp_err", rsp_err, mon_r.err);
               chk("rsp_rdata", rsp_rdata, mon_r.rdata);
               chk("rsp_cycle", cyc, mon_r.cyc);
            end
         end
         if (rd || wr || cs != 4'b0) begin
            chk("bus_pending", bus_q.size() > 0, 1);
            chk("bus_rw_overlap", rd && wr, 0);
            if (bus_q.size() > 0) begin
               mon_b = bus_q.pop_front();
               chk("bus_cs", cs, mon_b.cs);
               chk("bus_read", rd, !mon_b.we);
               chk("bus_write", wr, mon_b.we);
               chk("bus_address", addr_o, mon_b.adr);
               chk("bus_cycle", cyc, mon_b.cyc);
               if (mon_b.we) chk("bus_writedata", wdata_o, mon_b.wdata);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c1, c2, acc, a, v;
      int sel, slot, word;
      bit got;

      for (int k = 0; k < NS; k++) begin
         for (int w = 0; w < 8; w++) begin
            v = $urandom;
            slv_mem[k][w] = v;
            ref_mem[k][w] = v;
         end
      end
      slv_mem[2][2] = 32'h1234_5678;
      ref_mem[2][2] = 32'h1234_5678;

      // reset state
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_cs", cs, 0);
      chk("rst_strobes", {rd, wr}, 0);
      chk("rst_address", addr_o, 0);
      chk("rst_writedata", wdata_o, 0);
      chk("rst_l3_ready", r3_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // GPIO write, slot-2 read, errors and window boundaries
      send(1'b1, 32'h4000_0004, 32'hA5A5_A5A5, 1, acc);
      req_valid = 1'b0; repeat (2) @(negedge clk);
      send(1'b0, 32'h4000_2008, 32'h0, 1, acc);
      req_valid = 1'b0; repeat (3) @(negedge clk);
      send(1'b0, 32'h5000_0000, 32'h0, 1, acc);
      req_valid = 1'b0; repeat (2) @(negedge clk);
      send(1'b0, 32'h4000_0002, 32'h0, 1, acc);
      send(1'b0, 32'h3FFF_FFFC, 32'h0, 1, acc);
      send(1'b1, 32'h4000_4000, 32'h1111_2222, 1, acc);
      send(1'b1, 32'h4000_3FFC, 32'h3333_4444, 1, acc);
      send(1'b0, 32'h4000_3FFC, 32'h0, 1, acc);
      req_valid = 1'b0; repeat (3) @(negedge clk);

      // back-to-back writes with valid held high
      send(1'b1, 32'h4000_1000, 32'hDEAD_0001, 1, c1);
      send(1'b1, 32'h4000_1004, 32'hDEAD_0002, 1, c2);
      req_valid = 1'b0;
      chk("b2b_accept_gap", c2 - c1, 3);
      repeat (3) @(negedge clk);

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         sel  = $urandom_range(0, 9);
         slot = $urandom_range(0, NS - 1);
         word = $urandom_range(0, 1023);
         a = BASE + 32'(slot * SLOT_SZ) + 32'(word * 4);
         if (sel == 7) a = a | 32'($urandom_range(1, 3));
         else if (sel == 8) a = $urandom;
         else if (sel == 9) a = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                            : BASE + 32'h4000 + 32'(4 * $urandom_range(0, 4));
         send(1'($urandom_range(0, 1)), a, $urandom, 1, acc);
         if ($urandom_range(0, 2) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);

      // reset while the read is waiting for slave data: the response must vanish
      send(1'b0, 32'h4000_1010, 32'h0, 0, acc);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_rsp_rdata", rsp_rdata, 0);
      chk("midrst_rsp_err", rsp_err, 0);
      chk("midrst_cs", cs, 0);
      chk("midrst_strobes", {rd, wr}, 0);
      chk("midrst_address", addr_o, 0);
      chk("midrst_writedata", wdata_o, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // latency-3 instance: read slot 3 word 3
      r3_valid = 1'b1; r3_we = 1'b0; r3_addr = 32'h4000_300C; r3_wdata = 32'h0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         if (r3_ready) got = 1'b1;
         else @(negedge clk);
      end
      chk("l3_accept_timeout", got, 1);
      @(negedge clk);
      r3_valid = 1'b0;
      chk("l3_read_strobe", r3_rd, 1);
      chk("l3_cs", r3_cs, 4'b1000);
      chk("l3_address", r3_addr_o, 3);
      chk("l3_rsp_early", r3_rsp_valid, 0);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("l3_rsp_valid", r3_rsp_valid, 1'(k == 5));
         chk("l3_strobe_idle", {r3_rd, r3_wr, r3_cs}, 0);
         if (k == 5) begin
            chk("l3_rsp_rdata", r3_rsp_rdata, L3_VAL + 32'd3);
            chk("l3_rsp_err", r3_rsp_err, 0);
         end
      end
      @(negedge clk);
      chk("l3_rsp_done", r3_rsp_valid, 0);
      chk("l3_ready_again", r3_ready, 1);

      repeat (6) @(negedge clk);
      chk("rsp_queue_drained", exp_q.size(), 0);
      chk("bus_queue_drained", bus_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
